// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM multi-port arbiter.
package sdram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Width of a port index; a single-port build still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arb_rr_pick.sv
// Combinational masked picker: round-robin from a start index, or lowest index first.
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MODE      = ARB_RR,
  parameter int IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [NUM_PORTS-1:0] i_mask,
  input  logic [IDX_W-1:0]     i_start,
  output logic                 o_valid,
  output logic [IDX_W-1:0]     o_grant
);

  logic [NUM_PORTS-1:0] w_cand;
  int                   w_idx;

  assign w_cand = i_req & ~i_mask;

  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    w_idx   = 0;
    if (MODE == ARB_FIXED) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (w_cand[i]) begin
          o_valid = 1'b1;
          o_grant = IDX_W'(i);
        end
      end
    end else begin
      // Walk the ring starting at i_start; the first hit wins.
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_idx = int'(i_start) + k;
        if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
        if (!o_valid && w_cand[w_idx]) begin
          o_valid = 1'b1;
          o_grant = IDX_W'(w_idx);
        end
      end
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// N-client front end for the single-port SDRAM controller; one transaction per cep slot.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int DS_W      = DATA_W / 8,
  parameter int ARB_MODE  = ARB_RR
) (
  input  logic                        clk_sys,
  input  logic                        RESET,
  input  logic                        cep,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] port_din,
  input  logic [NUM_PORTS*DS_W-1:0]   port_ds,
  output logic [NUM_PORTS-1:0]        port_ack,
  output logic [DATA_W-1:0]           port_dout,
  output logic [ADDR_W-1:0]           sdram_addr,
  output logic [DATA_W-1:0]           sdram_din,
  output logic [DS_W-1:0]             sdram_ds,
  output logic                        sdram_we,
  output logic                        sdram_oe,
  input  logic [DATA_W-1:0]           sdram_out
);

  localparam int                IDX_W    = idx_w(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  arb_state_t           r_state;
  logic [IDX_W-1:0]     r_grant;
  logic [IDX_W-1:0]     r_last;
  logic [NUM_PORTS-1:0] r_ack;
  logic [DATA_W-1:0]    r_dout;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_din;
  logic [DS_W-1:0]      r_ds;
  logic                 r_we;
  logic                 r_oe;

  logic [IDX_W-1:0]     w_start;
  logic [NUM_PORTS-1:0] w_done;
  logic                 w_valid;
  logic [IDX_W-1:0]     w_pick;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_din;
  logic [DS_W-1:0]      w_sel_ds;
  logic                 w_sel_we;

  assign w_start = (r_last >= LAST_IDX) ? '0 : r_last + 1'b1;

  // The port finishing this slot is masked so it cannot be re-granted at the same cep.
  always_comb begin
    w_done = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_done[i] = (r_state == BUSY) && (r_grant == IDX_W'(i));
    end
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .MODE      (ARB_MODE),
    .IDX_W     (IDX_W)
  ) u_pick (
    .i_req   (port_req),
    .i_mask  (w_done),
    .i_start (w_start),
    .o_valid (w_valid),
    .o_grant (w_pick)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_din  = '0;
    w_sel_ds   = '0;
    w_sel_we   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_pick == IDX_W'(i)) begin
        w_sel_addr = port_addr[i*ADDR_W +: ADDR_W];
        w_sel_din  = port_din[i*DATA_W +: DATA_W];
        w_sel_ds   = port_ds[i*DS_W +: DS_W];
        w_sel_we   = port_we[i];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= LAST_IDX;
      r_ack   <= '0;
      r_dout  <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_ds    <= '0;
      r_we    <= 1'b0;
      r_oe    <= 1'b0;
    end else begin
      r_ack <= '0;
      if (cep) begin
        if (r_state == BUSY) begin
          r_ack <= w_done;
          if (r_oe) r_dout <= sdram_out;
        end
        if (w_valid) begin
          r_state <= BUSY;
          r_grant <= w_pick;
          r_last  <= w_pick;
          r_addr  <= w_sel_addr;
          r_din   <= w_sel_din;
          r_ds    <= w_sel_ds;
          r_we    <= w_sel_we;
          r_oe    <= ~w_sel_we;
        end else begin
          // Address/data hold their last values through an idle slot.
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_oe    <= 1'b0;
        end
      end
    end
  end

  assign port_ack   = r_ack;
  assign port_dout  = r_dout;
  assign sdram_addr = r_addr;
  assign sdram_din  = r_din;
  assign sdram_ds   = r_ds;
  assign sdram_we   = r_we;
  assign sdram_oe   = r_oe;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: 3 ports, cep period 8, round-robin and fixed-priority instances.
module tb_sdram_port_arb;
  import sdram_arb_pkg::*;

  localparam int NP  = 3;
  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int SW  = 2;
  localparam int PER = 8;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic             rst, cep;
  logic [NP-1:0]    req_rr, req_fx, we;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] din;
  logic [NP*SW-1:0] ds;
  logic [DW-1:0]    sd_out;

  logic [NP-1:0] ack_r, ack_f;
  logic [DW-1:0] dout_r, dout_f, sdin_r, sdin_f;
  logic [AW-1:0] sa_r, sa_f;
  logic [SW-1:0] sds_r, sds_f;
  logic          swe_r, soe_r, swe_f, soe_f;

  int n_cmp = 0;
  int n_bad = 0;

  sdram_port_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .DS_W(SW), .ARB_MODE(ARB_RR)) dut_rr (
    .clk_sys(clk_sys), .RESET(rst), .cep(cep), .port_req(req_rr), .port_we(we),
    .port_addr(addr), .port_din(din), .port_ds(ds), .port_ack(ack_r), .port_dout(dout_r),
    .sdram_addr(sa_r), .sdram_din(sdin_r), .sdram_ds(sds_r), .sdram_we(swe_r),
    .sdram_oe(soe_r), .sdram_out(sd_out));

  sdram_port_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .DS_W(SW), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk_sys(clk_sys), .RESET(rst), .cep(cep), .port_req(req_fx), .port_we(we),
    .port_addr(addr), .port_din(din), .port_ds(ds), .port_ack(ack_f), .port_dout(dout_f),
    .sdram_addr(sa_f), .sdram_din(sdin_f), .sdram_ds(sds_f), .sdram_we(swe_f),
    .sdram_oe(soe_f), .sdram_out(sd_out));

  // Slot-level reference model; index 0 = round-robin, 1 = fixed priority.
  bit            m_busy [2];
  int            m_g    [2];
  int            m_last [2];
  logic [NP-1:0] m_ack  [2];
  logic [DW-1:0] m_dout [2];
  logic [DW-1:0] m_din  [2];
  logic [AW-1:0] m_addr [2];
  logic [SW-1:0] m_ds   [2];
  logic          m_we   [2];
  logic          m_oe   [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_g[d] = 0; m_last[d] = NP - 1; m_ack[d] = '0;
      m_dout[d] = '0; m_din[d] = '0; m_addr[d] = '0; m_ds[d] = '0;
      m_we[d] = 1'b0; m_oe[d] = 1'b0;
    end
  endfunction

  function automatic void model_cep(int d, logic [NP-1:0] req);
    int win;
    int p;
    win = -1;
    m_ack[d] = '0;
    if (m_busy[d]) begin
      m_ack[d][m_g[d]] = 1'b1;
      if (m_oe[d]) m_dout[d] = sd_out;
    end
    for (int k = 0; k < NP; k++) begin
      p = (d == 0) ? (m_last[d] + 1 + k) % NP : k;
      if (win < 0 && req[p] && !(m_busy[d] && p == m_g[d])) win = p;
    end
    if (win >= 0) begin
      m_busy[d] = 1'b1; m_g[d] = win; m_last[d] = win;
      m_we[d] = we[win]; m_oe[d] = ~we[win];
      m_addr[d] = addr[win*AW +: AW]; m_din[d] = din[win*DW +: DW]; m_ds[d] = ds[win*SW +: SW];
    end else begin
      m_busy[d] = 1'b0; m_we[d] = 1'b0; m_oe[d] = 1'b0;
    end
  endfunction

  // Drives one cep pulse and returns at the negedge after it, when the slot's outputs are visible.
  task automatic cep_slot();
    @(negedge clk_sys);
    cep = 1'b1;
    model_cep(0, req_rr);
    model_cep(1, req_fx);
    @(negedge clk_sys);
    cep = 1'b0;
  endtask

  task automatic gap(int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst = 1'b1; cep = 1'b0; req_rr = '0; req_fx = '0;
    @(negedge clk_sys);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_port(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] dd, logic [SW-1:0] s);
    we[i] = w; addr[i*AW +: AW] = a; din[i*DW +: DW] = dd; ds[i*SW +: SW] = s;
  endtask

  task automatic test_reset();
    cep = 1'b0; req_rr = '0; req_fx = '0; we = '1; addr = '1; din = '1; ds = '1; sd_out = '1;
    rst = 1'b1;
    gap(3);
    n_cmp++;
    if ({ack_r, dout_r, sa_r, sdin_r, sds_r, swe_r, soe_r} !== '0) begin
      n_bad++;
      $display("FAIL reset_rr: got ack=%b dout=%h addr=%h din=%h ds=%b we=%b oe=%b want all zero",
               ack_r, dout_r, sa_r, sdin_r, sds_r, swe_r, soe_r);
    end
    n_cmp++;
    if ({ack_f, dout_f, sa_f, sdin_f, sds_f, swe_f, soe_f} !== '0) begin
      n_bad++;
      $display("FAIL reset_fx: got ack=%b dout=%h addr=%h we=%b oe=%b want all zero",
               ack_f, dout_f, sa_f, swe_f, soe_f);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    set_port(1, 1'b0, 25'h0001234, 16'h0000, 2'b11);
    req_rr = 3'b010;
    cep_slot();
    n_cmp++;
    if ({swe_r, soe_r} !== 2'b01) begin
      n_bad++; $display("FAIL rd_weoe: got %b want 01", {swe_r, soe_r});
    end
    n_cmp++;
    if (sa_r !== 25'h0001234) begin
      n_bad++; $display("FAIL rd_addr: got %h want 0001234", sa_r);
    end
    gap(2);
    n_cmp++;
    if (ack_r !== 3'b000) begin
      n_bad++; $display("FAIL rd_early_ack: got %b want 000", ack_r);
    end
    gap(4);
    sd_out = 16'hBEEF;
    cep_slot();
    n_cmp++;
    if (ack_r !== 3'b010) begin
      n_bad++; $display("FAIL rd_ack: got %b want 010", ack_r);
    end
    n_cmp++;
    if (dout_r !== 16'hBEEF) begin
      n_bad++; $display("FAIL rd_dout: got %h want beef", dout_r);
    end
    req_rr = 3'b000;
    sd_out = 16'h1111;
    gap(1);
    n_cmp++;
    if ({ack_r, dout_r} !== {3'b000, 16'hBEEF}) begin
      n_bad++; $display("FAIL rd_ack_pulse: got ack=%b dout=%h want ack=000 dout=beef", ack_r, dout_r);
    end
    gap(5);
    cep_slot();
    n_cmp++;
    if ({swe_r, soe_r, dout_r} !== {2'b00, 16'hBEEF}) begin
      n_bad++; $display("FAIL rd_idle: got we/oe=%b dout=%h want 00 beef", {swe_r, soe_r}, dout_r);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    set_port(0, 1'b1, 25'h0000777, 16'h5A5A, 2'b01);
    req_rr = 3'b001;
    cep_slot();
    n_cmp++;
    if ({swe_r, soe_r, sds_r, sdin_r} !== {2'b10, 2'b01, 16'h5A5A}) begin
      n_bad++; $display("FAIL wr_issue: got we/oe=%b ds=%b din=%h want 10 01 5a5a", {swe_r, soe_r}, sds_r, sdin_r);
    end
    gap(PER - 2);
    cep_slot();
    req_rr = 3'b000;
    n_cmp++;
    if ({ack_r, swe_r, soe_r} !== {3'b001, 2'b00}) begin
      n_bad++; $display("FAIL wr_done: got ack=%b we/oe=%b want 001 00", ack_r, {swe_r, soe_r});
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ea;
    logic [NP-1:0] eack;
    do_reset();
    for (int i = 0; i < NP; i++) set_port(i, 1'b0, AW'(256 + i), 16'h0, 2'b11);
    req_rr = 3'b111;
    for (int s = 0; s < 6; s++) begin
      cep_slot();
      ea = AW'(256 + (s % 3));
      n_cmp++;
      if ({sa_r, soe_r} !== {ea, 1'b1}) begin
        n_bad++; $display("FAIL rr_order[%0d]: got addr=%h oe=%b want addr=%h oe=1", s, sa_r, soe_r, ea);
      end
      if (s > 0) begin
        eack = '0; eack[(s - 1) % 3] = 1'b1;
        n_cmp++;
        if (ack_r !== eack) begin
          n_bad++; $display("FAIL rr_ack[%0d]: got %b want %b", s, ack_r, eack);
        end
      end
      gap(PER - 2);
    end
    req_rr = 3'b000;
  endtask

  task automatic test_fixed();
    logic [AW-1:0] ea;
    do_reset();
    for (int i = 0; i < NP; i++) set_port(i, 1'b0, AW'(512 + i), 16'h0, 2'b11);
    req_fx = 3'b101;
    for (int s = 0; s < 4; s++) begin
      cep_slot();
      ea = (s % 2 == 1) ? AW'(514) : AW'(512);
      n_cmp++;
      if ({sa_f, soe_f} !== {ea, 1'b1}) begin
        n_bad++; $display("FAIL fx_order[%0d]: got addr=%h oe=%b want addr=%h oe=1", s, sa_f, soe_f, ea);
      end
      gap(PER - 2);
    end
    req_fx = 3'b000;
  endtask

  task automatic test_lone();
    do_reset();
    set_port(2, 1'b0, 25'h1ABCDEF, 16'h0, 2'b11);
    req_rr = 3'b100;
    for (int s = 0; s < 6; s++) begin
      cep_slot();
      n_cmp++;
      if (s % 2 == 0) begin
        if ({swe_r, soe_r, sa_r} !== {2'b01, 25'h1ABCDEF}) begin
          n_bad++; $display("FAIL lone_grant[%0d]: got we/oe=%b addr=%h want 01 1abcdef", s, {swe_r, soe_r}, sa_r);
        end
      end else begin
        if ({ack_r, swe_r, soe_r} !== {3'b100, 2'b00}) begin
          n_bad++; $display("FAIL lone_idle[%0d]: got ack=%b we/oe=%b want 100 00", s, ack_r, {swe_r, soe_r});
        end
      end
      gap(PER - 2);
    end
    req_rr = 3'b000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_port(0, 1'b1, 25'h0000AAA, 16'hC0DE, 2'b10);
    set_port(1, 1'b0, 25'h0000BBB, 16'h0, 2'b11);
    req_rr = 3'b010;
    cep_slot();
    n_cmp++;
    if ({soe_r, sa_r} !== {1'b1, 25'h0000BBB}) begin
      n_bad++; $display("FAIL mid_busy: got oe=%b addr=%h want 1 0000bbb", soe_r, sa_r);
    end
    gap(2);
    rst = 1'b1;
    @(negedge clk_sys);
    n_cmp++;
    if ({ack_r, dout_r, sa_r, sdin_r, sds_r, swe_r, soe_r} !== '0) begin
      n_bad++; $display("FAIL mid_reset: got ack=%b addr=%h we=%b oe=%b want all zero", ack_r, sa_r, swe_r, soe_r);
    end
    rst = 1'b0;
    model_reset();
    req_rr = 3'b011;
    gap(3);
    cep_slot();
    n_cmp++;
    if ({ack_r, swe_r, soe_r, sa_r, sdin_r} !== {3'b000, 2'b10, 25'h0000AAA, 16'hC0DE}) begin
      n_bad++; $display("FAIL mid_regrant: got ack=%b we/oe=%b addr=%h din=%h want 000 10 0000aaa c0de",
                        ack_r, {swe_r, soe_r}, sa_r, sdin_r);
    end
    gap(PER - 2);
    cep_slot();
    req_rr = 3'b010;
    n_cmp++;
    if ({ack_r, sa_r} !== {3'b001, 25'h0000BBB}) begin
      n_bad++; $display("FAIL mid_next: got ack=%b addr=%h want 001 0000bbb", ack_r, sa_r);
    end
    gap(PER - 2);
    cep_slot();
    req_rr = 3'b000;
  endtask

  task automatic new_req(int i);
    set_port(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom));
  endtask

  task automatic test_random(int d);
    logic [NP-1:0] req;
    logic [NP-1:0] a_ack;
    logic [AW+DW+SW+1:0] a_bus, e_bus;
    logic [DW-1:0] a_dout;
    do_reset();
    req = '0;
    for (int s = 0; s < 60; s++) begin
      sd_out = DW'($urandom);
      cep_slot();
      a_ack  = d ? ack_f : ack_r;
      a_dout = d ? dout_f : dout_r;
      a_bus  = d ? {swe_f, soe_f, sa_f, sdin_f, sds_f} : {swe_r, soe_r, sa_r, sdin_r, sds_r};
      e_bus  = {m_we[d], m_oe[d], m_addr[d], m_din[d], m_ds[d]};
      n_cmp++;
      if (a_ack !== m_ack[d]) begin
        n_bad++; $display("FAIL rnd%0d_ack[%0d]: got %b want %b", d, s, a_ack, m_ack[d]);
      end
      n_cmp++;
      if (a_bus !== e_bus) begin
        n_bad++; $display("FAIL rnd%0d_bus[%0d]: got %h want %h", d, s, a_bus, e_bus);
      end
      n_cmp++;
      if (a_dout !== m_dout[d]) begin
        n_bad++; $display("FAIL rnd%0d_dout[%0d]: got %h want %h", d, s, a_dout, m_dout[d]);
      end
      gap(1);
      for (int i = 0; i < NP; i++) begin
        if (m_ack[d][i]) begin
          req[i] = 1'($urandom_range(0, 1));
          new_req(i);
        end else if (!req[i] && $urandom_range(0, 2) != 0) begin
          req[i] = 1'b1;
          new_req(i);
        end
      end
      if (d == 0) req_rr = req; else req_fx = req;
      gap(1);
      a_ack = d ? ack_f : ack_r;
      a_bus = d ? {swe_f, soe_f, sa_f, sdin_f, sds_f} : {swe_r, soe_r, sa_r, sdin_r, sds_r};
      n_cmp++;
      if ({a_ack, a_bus} !== {{NP{1'b0}}, e_bus}) begin
        n_bad++; $display("FAIL rnd%0d_hold[%0d]: got ack=%b bus=%h want ack=000 bus=%h", d, s, a_ack, a_bus, e_bus);
      end
      gap(PER - 4);
    end
    req_rr = '0;
    req_fx = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_fixed();
    test_lone();
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
